// File: rtl/lfa_pkg.sv
// Shared types and constants for the LFA sensor ADC reader.
package lfa_pkg;

  localparam int FRAME_PHASES = 32;
  localparam int ADC_BITS     = 12;
  localparam int PHASE_W      = $clog2(FRAME_PHASES);

  typedef enum logic [1:0] {SLOT_L, SLOT_M, SLOT_R} slot_e;
  typedef enum logic [1:0] {IDLE, GAP, FRAME} state_e;

  function automatic slot_e next_slot(input slot_e s);
    case (s)
      SLOT_L:  return SLOT_M;
      SLOT_M:  return SLOT_R;
      default: return SLOT_L;
    endcase
  endfunction

endpackage

// File: rtl/adc_spi_frame.sv
// One ADC128S022-style SPI frame: phase counter, SCK/DIN generation and serial capture.
module adc_spi_frame
  import lfa_pkg::*;
(
  input  logic                clk_3125KHz,
  input  logic                reset,
  input  logic                active,
  input  logic [2:0]          addr,
  input  logic                adc_dout,
  output logic                adc_sck,
  output logic                adc_din,
  output logic                last_phase,
  output logic [ADC_BITS-1:0] result
);

  logic [PHASE_W-1:0]  phase_p0;
  logic [ADC_BITS-2:0] shift_p0;
  logic [3:0]          bit_idx;

  always_ff @(posedge clk_3125KHz) begin
    if (reset || !active) phase_p0 <= '0;
    else                  phase_p0 <= phase_p0 + 1'b1;
  end

  // The four leading bits simply fall off the top of the shifter.
  always_ff @(posedge clk_3125KHz) begin
    if (active && phase_p0[0]) shift_p0 <= {shift_p0[ADC_BITS-3:0], adc_dout};
  end

  assign bit_idx    = phase_p0[PHASE_W-1:1];
  assign adc_sck    = active ? phase_p0[0] : 1'b1;
  assign last_phase = active && (phase_p0 == PHASE_W'(FRAME_PHASES - 1));
  // The LSB is sampled on the same edge that consumes the result.
  assign result     = {shift_p0, adc_dout};

  always_comb begin
    adc_din = 1'b0;
    if (active) begin
      case (bit_idx)
        4'd2:    adc_din = addr[2];
        4'd3:    adc_din = addr[1];
        4'd4:    adc_din = addr[0];
        default: adc_din = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/lfa_adc_reader.sv
// Round-robin left/middle/right ADC reader for the LFA sensor bus.
// Define LFA_AVG_EN to output the two-sample average per slot instead of the raw result.
module lfa_adc_reader
  import lfa_pkg::*;
#(
  parameter logic [2:0] CH_LEFT    = 3'd0,
  parameter logic [2:0] CH_MIDDLE  = 3'd1,
  parameter logic [2:0] CH_RIGHT   = 3'd2,
  parameter int         GAP_CYCLES = 2
) (
  input  logic                clk_3125KHz,
  input  logic                reset,
  input  logic                enable,
  input  logic                adc_dout,
  output logic                adc_cs_n,
  output logic                adc_sck,
  output logic                adc_din,
  output logic [ADC_BITS-1:0] left,
  output logic [ADC_BITS-1:0] middle,
  output logic [ADC_BITS-1:0] right,
  output logic                data_valid
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e              state, state_nxt;
  slot_e               slot;
  logic                priming;
  logic [GAP_W-1:0]    gap_cnt;
  logic                gap_done;
  logic                frame_active;
  logic                last_phase;
  logic                write_en;
  logic [2:0]          addr;
  logic [ADC_BITS-1:0] result;
  logic [ADC_BITS-1:0] slot_value;

  function automatic logic [2:0] chan_of(input slot_e s);
    case (s)
      SLOT_L:  return CH_LEFT;
      SLOT_M:  return CH_MIDDLE;
      default: return CH_RIGHT;
    endcase
  endfunction

  assign frame_active = (state == FRAME);
  assign adc_cs_n     = !frame_active;
  assign gap_done     = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign write_en     = last_phase && !priming;
  // The ADC returns the channel addressed in the previous frame.
  assign addr         = priming ? CH_LEFT : chan_of(next_slot(slot));

  always_ff @(posedge clk_3125KHz) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = FRAME;
      FRAME:   if (last_phase) state_nxt = GAP;
      GAP:     if (gap_done) state_nxt = enable ? FRAME : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_3125KHz) begin
    if (reset || state != GAP) gap_cnt <= '0;
    else                       gap_cnt <= gap_cnt + 1'b1;
  end

  always_ff @(posedge clk_3125KHz) begin
    if (reset || state == IDLE) begin
      slot    <= SLOT_L;
      priming <= 1'b1;
    end else if (last_phase) begin
      if (priming) priming <= 1'b0;
      else         slot    <= next_slot(slot);
    end
  end

  adc_spi_frame u_frame (
    .clk_3125KHz (clk_3125KHz),
    .reset       (reset),
    .active      (frame_active),
    .addr        (addr),
    .adc_dout    (adc_dout),
    .adc_sck     (adc_sck),
    .adc_din     (adc_din),
    .last_phase  (last_phase),
    .result      (result)
  );

`ifdef LFA_AVG_EN
  logic [ADC_BITS-1:0] prev_p0 [3];
  logic [2:0]          have_prev;

  function automatic logic [ADC_BITS-1:0] avg2(input logic [ADC_BITS-1:0] a,
                                               input logic [ADC_BITS-1:0] b);
    logic [ADC_BITS:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[ADC_BITS:1];
  endfunction

  always_ff @(posedge clk_3125KHz) begin
    if (reset)         have_prev       <= '0;
    else if (write_en) have_prev[slot] <= 1'b1;
  end

  always_ff @(posedge clk_3125KHz) begin
    if (write_en) prev_p0[slot] <= result;
  end

  assign slot_value = have_prev[slot] ? avg2(prev_p0[slot], result) : result;
`else
  assign slot_value = result;
`endif

  always_ff @(posedge clk_3125KHz) begin
    if (reset) begin
      left       <= '0;
      middle     <= '0;
      right      <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= write_en && (slot == SLOT_R);
      if (write_en) begin
        case (slot)
          SLOT_L:  left   <= slot_value;
          SLOT_M:  middle <= slot_value;
          default: right  <= slot_value;
        endcase
      end
    end
  end

endmodule

// File: doc/lfa_adc_reader.md
LFA_ADC_READER -- requirements
Module: lfa_adc_reader

Interface
REQ-001 SHALL have parameter CH_LEFT, default 3'd0, ADC input channel for the left sensor.
REQ-002 SHALL have parameter CH_MIDDLE, default 3'd1, ADC input channel for the middle sensor.
REQ-003 SHALL have parameter CH_RIGHT, default 3'd2, ADC input channel for the right sensor.
REQ-004 SHALL have parameter GAP_CYCLES, default 2, CS-high clocks between frames (min 1).
REQ-005 SHALL have port clk_3125KHz  input  1  sole clock; one clock domain, all logic on posedge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port enable  input  1  1 = run conversions continuously.
REQ-008 SHALL have port adc_dout  input  1  serial data from the ADC (ADC128S022-type).
REQ-009 SHALL have port adc_cs_n  output  1  ADC chip select, active low.
REQ-010 SHALL have port adc_sck  output  1  serial clock, clk/2 inside a frame, idles high.
REQ-011 SHALL have port adc_din  output  1  serial channel-address bits to the ADC.
REQ-012 SHALL have ports left, middle, right  output  12 each  latest sensor values, LFA sensor bus.
REQ-013 SHALL have port data_valid  output  1  one-cycle pulse when a full left/middle/right set has completed.

Function
REQ-014 SHALL use states IDLE, GAP, FRAME; IDLE->FRAME when enable=1; FRAME->GAP after phase 31; GAP->FRAME after GAP_CYCLES when enable=1, else GAP->IDLE.
REQ-015 SHALL count frame phase p = 0..31; bit b = p>>1; adc_cs_n=0 for all of FRAME; adc_sck=0 on even p, 1 on odd p; adc_sck=1 outside FRAME.
REQ-016 SHALL drive adc_din for bit b over phases 2b and 2b+1: b=2,3,4 carry ADD2,ADD1,ADD0; all other bits 0.
REQ-017 SHALL sample adc_dout on the clock edge that ends each odd phase, keeping bits b=4..15 MSB-first as the 12-bit result; bits 0..3 are discarded.
REQ-018 SHALL run the slot sequence L,M,R,L,...: the frame for slot k sends the address of slot (k+1) mod 3 and writes its result to slot k's output.
REQ-019 SHALL precede the first slot-L frame with a priming frame after reset or IDLE; the priming frame sends CH_LEFT and its data is discarded.
REQ-020 SHALL update an output register on the clock after phase 31 of its frame; other outputs hold their values.
REQ-021 SHALL pulse data_valid for exactly one clock, coincident with the right update.
REQ-022 SHALL give a set period of 3*(32+GAP_CYCLES) clocks (102 at default) in steady state.
REQ-023 SHALL complete the current frame, including its output write, when enable falls mid-frame, then go GAP->IDLE; no new frame starts.
REQ-024 SHALL return to the priming frame and slot L when enable rises again.

Reset
REQ-025 SHALL put outputs into this state on the clock where reset=1: state IDLE, adc_cs_n=1, adc_sck=1, adc_din=0, left=middle=right=0, data_valid=0, slot=L, phase=0.
REQ-026 SHALL abort a frame when reset is asserted mid-frame; adc_cs_n goes high on that edge, and the partial result is discarded.
REQ-027 SHALL give reset priority over enable.

Configuration
REQ-028 SHALL, when macro LFA_AVG_EN is defined, make each output the average of the last two results for that slot, computed as a 13-bit sum >>1 (truncating), using the first result alone after reset.
REQ-029 SHALL, when LFA_AVG_EN is undefined, make each output the raw latest result, with no averaging registers.

Structure
REQ-030 SHALL place the following in shared package lfa_pkg: the slot enum (SLOT_L, SLOT_M, SLOT_R), FRAME_PHASES=32, ADC_BITS=12, and the state enum.
REQ-031 SHALL implement one SPI frame (phase counter, sck/din generation, 16-bit shift-in) in sub-module adc_spi_frame, instantiated once; slot sequencing and output registers stay in the top module.

Verification
REQ-032 SHALL cover this case: ADC model returns channel*0x111 -> after the priming frame, left=0x000, middle=0x111, right=0x222; data_valid pulses once every 102 clocks.
REQ-033 SHALL cover this case: CH_LEFT=5, CH_MIDDLE=6, CH_RIGHT=7 -> captured DIN addresses per frame are 5 (priming), 6, 7, 5, 6...; outputs match the model values for channels 5/6/7.
REQ-034 SHALL cover this case: reset asserted at phase 17 -> next edge adc_cs_n=1, outputs 0, no data_valid; after release plus enable, a priming frame precedes the first valid set.
REQ-035 SHALL cover this case: enable dropped at phase 10 of the middle frame -> the frame completes, middle updates, CS stays high, right is not updated, no data_valid.
REQ-036 SHALL cover this case: with LFA_AVG_EN defined and left results 0xFFF then 0x001 -> left shows 0xFFF, then 0x800; without the macro -> 0xFFF, then 0x001.
REQ-037 SHALL cover this case: the DOUT model drives 1s in the leading 4 bits -> the outputs ignore them (result bits 15..12 never appear).
